// File: rtl/video_pkg.sv
// Shared types, default 256x224 raster timing and sync-position clamp for the
// video timing generator family.
package video_pkg;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs_n;
        logic vs_n;
    } sb_t;

    localparam int unsigned SB_W = $bits(sb_t);
    localparam sb_t SB_IDLE = '{hb: 1'b1, vb: 1'b1, hs_n: 1'b1, vs_n: 1'b1};

    localparam int unsigned DEF_CW          = 10;
    localparam int unsigned DEF_RGB_W       = 12;
    localparam int unsigned DEF_H_TOTAL     = 384;
    localparam int unsigned DEF_H_ACT       = 256;
    localparam int unsigned DEF_V_TOTAL     = 262;
    localparam int unsigned DEF_V_ACT       = 224;
    localparam int unsigned DEF_H_SYNC_BASE = 304;
    localparam int unsigned DEF_H_SYNC_W    = 32;
    localparam int unsigned DEF_V_SYNC_BASE = 236;
    localparam int unsigned DEF_V_SYNC_W    = 3;
    localparam int unsigned DEF_H_STEP      = 2;
    localparam int unsigned DEF_V_STEP      = 1;
    localparam int unsigned DEF_OFS_W       = 5;
    localparam int unsigned DEF_PIX_DLY     = 2;

    // Keeps a sync start inside the blanking interval so it neither overlaps
    // active video nor wraps past the line/frame end.
    function automatic int clamp_sync(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// Clock-enabled shift register of configurable depth and width; DEPTH=0 is a
// straight wire.
module vtg_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [W-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_ce) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters on a pixel clock-enable,
// flip-aware coordinates, offset-adjustable sync and a pixel-latency matched
// blank/sync/RGB output stage.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned CW          = DEF_CW,
    parameter int unsigned RGB_W       = DEF_RGB_W,
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned H_ACT       = DEF_H_ACT,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned V_ACT       = DEF_V_ACT,
    parameter int unsigned H_SYNC_BASE = DEF_H_SYNC_BASE,
    parameter int unsigned H_SYNC_W    = DEF_H_SYNC_W,
    parameter int unsigned V_SYNC_BASE = DEF_V_SYNC_BASE,
    parameter int unsigned V_SYNC_W    = DEF_V_SYNC_W,
    parameter int unsigned H_STEP      = DEF_H_STEP,
    parameter int unsigned V_STEP      = DEF_V_STEP,
    parameter int unsigned OFS_W       = DEF_OFS_W,
    parameter int unsigned PIX_DLY     = DEF_PIX_DLY
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             CE_PIX,
    input  logic [OFS_W-1:0] HOFFS,
    input  logic [OFS_W-1:0] VOFFS,
    input  logic             FLIP,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CW-1:0]    HPOS,
    output logic [CW-1:0]    VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             FRAME_ST
);

    localparam int unsigned SW  = CW + OFS_W + 2;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned DW  = SB_W + 1;

    logic [CW-1:0]        r_hcnt;
    logic [CW-1:0]        r_vcnt;
    logic [OFS_W-1:0]     r_hoffs_l;
    logic [OFS_W-1:0]     r_voffs_l;
    logic                 w_h_end;
    logic                 w_v_end;
    logic                 w_frame0;
    logic signed [SW-1:0] w_hofs_x;
    logic signed [SW-1:0] w_vofs_x;
    logic signed [SW-1:0] w_hsb_raw;
    logic signed [SW-1:0] w_vsb_raw;
    logic [CW-1:0]        w_hsb;
    logic [CW-1:0]        w_vsb;
    sb_t                  w_raw;
    logic [DW-1:0]        w_dly_bus;
    sb_t                  w_dly;
    logic                 w_f0_dly;
    sb_t                  r_sb;
    logic [RGB_W-1:0]     r_rgb;
    logic                 r_frame_st;

    assign w_h_end  = (r_hcnt == CW'(H_TOTAL - 1));
    assign w_v_end  = (r_vcnt == CW'(V_TOTAL - 1));
    assign w_frame0 = (r_hcnt == '0) && (r_vcnt == '0);

    // Raster counters
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (CE_PIX) begin
            if (w_h_end) begin
                r_hcnt <= '0;
                if (w_v_end) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + 1'b1;
                end
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Offsets only take effect at a frame boundary so sync never jumps mid-frame
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hoffs_l <= '0;
            r_voffs_l <= '0;
        end else if (CE_PIX && w_frame0) begin
            r_hoffs_l <= HOFFS;
            r_voffs_l <= VOFFS;
        end
    end

    assign w_hofs_x  = {{(SW-OFS_W){r_hoffs_l[OFS_W-1]}}, r_hoffs_l};
    assign w_vofs_x  = {{(SW-OFS_W){r_voffs_l[OFS_W-1]}}, r_voffs_l};
    assign w_hsb_raw = SW'(H_SYNC_BASE) + w_hofs_x * SW'(H_STEP);
    assign w_vsb_raw = SW'(V_SYNC_BASE) + w_vofs_x * SW'(V_STEP);
    assign w_hsb = CW'(clamp_sync(int'(w_hsb_raw), int'(H_ACT), int'(H_TOTAL - H_SYNC_W)));
    assign w_vsb = CW'(clamp_sync(int'(w_vsb_raw), int'(V_ACT), int'(V_TOTAL - V_SYNC_W)));

    // Undelayed blank/sync from the counters; compared one bit wider so the
    // sync end never overflows when a total equals 2^CW
    always_comb begin
        w_raw      = SB_IDLE;
        w_raw.hb   = (r_hcnt >= CW'(H_ACT));
        w_raw.vb   = (r_vcnt >= CW'(V_ACT));
        w_raw.hs_n = !(({1'b0, r_hcnt} >= {1'b0, w_hsb}) &&
                       ({1'b0, r_hcnt} <  ({1'b0, w_hsb} + CW1'(H_SYNC_W))));
        w_raw.vs_n = !(({1'b0, r_vcnt} >= {1'b0, w_vsb}) &&
                       ({1'b0, r_vcnt} <  ({1'b0, w_vsb} + CW1'(V_SYNC_W))));
    end

    assign HPOS = (FLIP && (r_hcnt < CW'(H_ACT))) ? (CW'(H_ACT - 1) - r_hcnt) : r_hcnt;
    assign VPOS = (FLIP && (r_vcnt < CW'(V_ACT))) ? (CW'(V_ACT - 1) - r_vcnt) : r_vcnt;

    vtg_delay_line #(
        .DEPTH   (PIX_DLY),
        .W       (DW),
        .RST_VAL (DW'({SB_IDLE, 1'b0}))
    ) u_dly (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .i_ce  (CE_PIX),
        .i_d   ({w_raw, w_frame0}),
        .o_q   (w_dly_bus)
    );

    assign w_dly    = sb_t'(w_dly_bus[DW-1:1]);
    assign w_f0_dly = w_dly_bus[0];

    // Output stage; FRAME_ST is gated by CE so it lasts a single MCLK
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sb       <= SB_IDLE;
            r_rgb      <= '0;
            r_frame_st <= 1'b0;
        end else begin
            r_frame_st <= CE_PIX & w_f0_dly;
            if (CE_PIX) begin
                r_sb  <= w_dly;
                r_rgb <= (w_dly.hb | w_dly.vb) ? '0 : iRGB;
            end
        end
    end

    assign HBLK     = r_sb.hb;
    assign VBLK     = r_sb.vb;
    assign HSYN     = r_sb.hs_n;
    assign VSYN     = r_sb.vs_n;
    assign oRGB     = r_rgb;
    assign FRAME_ST = r_frame_st;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen: a frame-position reference
// model queues expected outputs each MCLK, a monitor pops and compares them.
module tb_video_timing_gen;

    localparam int HT    = 384;
    localparam int HACT  = 256;
    localparam int VT    = 20;
    localparam int VACT  = 12;
    localparam int HSB0  = 304;
    localparam int HSW   = 32;
    localparam int VSB0  = 14;
    localparam int VSW   = 3;
    localparam int HSTEP = 2;
    localparam int VSTEP = 1;
    localparam int PDLY  = 2;

    typedef struct packed {
        logic        hblk;
        logic        vblk;
        logic        hsyn;
        logic        vsyn;
        logic        fst;
        logic [11:0] rgb;
        logic [9:0]  hpos;
        logic [9:0]  vpos;
    } exp_t;

    logic              MCLK;
    logic              RESET_N;
    logic              CE_PIX;
    logic signed [4:0] HOFFS;
    logic signed [4:0] VOFFS;
    logic              FLIP;
    logic [11:0]       iRGB;
    logic [9:0]        HPOS;
    logic [9:0]        VPOS;
    logic [11:0]       oRGB;
    logic              HBLK;
    logic              VBLK;
    logic              HSYN;
    logic              VSYN;
    logic              FRAME_ST;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t       exp_q[$];
    logic [4:0] hist[$];
    exp_t       m_out;
    int         m_pos     = 0;
    int         m_lh      = 0;
    int         m_lv      = 0;
    int         m_frames  = 0;
    int         m_fst_cnt = 0;
    int         dut_fst_cnt = 0;

    video_timing_gen #(
        .CW(10), .RGB_W(12), .H_TOTAL(HT), .H_ACT(HACT), .V_TOTAL(VT), .V_ACT(VACT),
        .H_SYNC_BASE(HSB0), .H_SYNC_W(HSW), .V_SYNC_BASE(VSB0), .V_SYNC_W(VSW),
        .H_STEP(HSTEP), .V_STEP(VSTEP), .OFS_W(5), .PIX_DLY(PDLY)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HOFFS(HOFFS), .VOFFS(VOFFS),
        .FLIP(FLIP), .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK),
        .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN), .FRAME_ST(FRAME_ST)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // {hb, vb, hs_n, vs_n, frame_start} for a position within the frame
    function automatic logic [4:0] raw_of(input int pos, input int lh, input int lv);
        int h, v, hsb, vsb;
        h   = pos % HT;
        v   = pos / HT;
        hsb = clampi(HSB0 + lh * HSTEP, HACT, HT - HSW);
        vsb = clampi(VSB0 + lv * VSTEP, VACT, VT - VSW);
        return {h >= HACT, v >= VACT, !(h >= hsb && h < hsb + HSW),
                !(v >= vsb && v < vsb + VSW), pos == 0};
    endfunction

    // Reference model
    always @(posedge MCLK) begin
        logic [4:0] r;
        logic [4:0] d;
        int         h;
        int         v;
        if (!RESET_N) begin
            m_pos = 0;
            m_lh  = 0;
            m_lv  = 0;
            hist.delete();
            for (int i = 0; i < PDLY; i++) hist.push_back(5'b11110);
            m_out = '{hblk: 1'b1, vblk: 1'b1, hsyn: 1'b1, vsyn: 1'b1, fst: 1'b0,
                      rgb: 12'h0, hpos: 10'h0, vpos: 10'h0};
        end else if (CE_PIX) begin
            r = raw_of(m_pos, m_lh, m_lv);
            if (m_pos == 0) begin
                m_lh = int'(HOFFS);
                m_lv = int'(VOFFS);
                m_frames++;
            end
            hist.push_back(r);
            d = hist.pop_front();
            m_out.hblk = d[4];
            m_out.vblk = d[3];
            m_out.hsyn = d[2];
            m_out.vsyn = d[1];
            m_out.fst  = d[0];
            m_out.rgb  = (d[4] | d[3]) ? 12'h0 : iRGB;
            m_pos = (m_pos + 1) % (HT * VT);
        end else begin
            m_out.fst = 1'b0;
        end
        if (m_out.fst) m_fst_cnt++;
        h = m_pos % HT;
        v = m_pos / HT;
        m_out.hpos = 10'((FLIP && h < HACT) ? (HACT - 1 - h) : h);
        m_out.vpos = 10'((FLIP && v < VACT) ? (VACT - 1 - v) : v);
        exp_q.push_back(m_out);
    end

    // Monitor
    always @(posedge MCLK) begin
        exp_t e;
        #1;
        if (FRAME_ST === 1'b1) dut_fst_cnt++;
        if (exp_q.size() == 0) begin
            check("exp_avail", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("hblk",     32'(HBLK),     32'(e.hblk));
            check("vblk",     32'(VBLK),     32'(e.vblk));
            check("hsyn",     32'(HSYN),     32'(e.hsyn));
            check("vsyn",     32'(VSYN),     32'(e.vsyn));
            check("frame_st", 32'(FRAME_ST), 32'(e.fst));
            check("orgb",     32'(oRGB),     32'(e.rgb));
            check("hpos",     32'(HPOS),     32'(e.hpos));
            check("vpos",     32'(VPOS),     32'(e.vpos));
        end
    end

    // Stimulus
    initial begin
        logic signed [4:0] hoffs_tbl [4];
        logic signed [4:0] voffs_tbl [4];
        int cyc;
        int tgt;
        hoffs_tbl = '{5'sd0, 5'sd15, -5'sd16, 5'sd5};
        voffs_tbl = '{5'sd0, -5'sd16, 5'sd15, -5'sd3};
        RESET_N = 1'b0;
        CE_PIX  = 1'b0;
        HOFFS   = 5'sd0;
        VOFFS   = 5'sd0;
        FLIP    = 1'b0;
        iRGB    = 12'hABC;
        repeat (3) @(negedge MCLK);
        RESET_N = 1'b1;

        // Slow pixel rate, default offsets, constant pixel data
        for (int i = 0; i < 6400 && n_fail <= 50; i++) begin
            @(negedge MCLK);
            CE_PIX = (i % 8 == 7);
        end

        // Dense random CE, random pixels/flip, per-frame offsets plus ignored mid-frame changes
        tgt = m_frames + 4;
        cyc = 0;
        while (m_frames < tgt && cyc < 45000 && n_fail <= 50) begin
            @(negedge MCLK);
            cyc++;
            CE_PIX = ($urandom_range(0, 7) != 0);
            iRGB   = 12'($urandom);
            if ($urandom_range(0, 499) == 0) FLIP = ~FLIP;
            if ($urandom_range(0, 999) == 0 || m_pos == 10 * HT + 37) begin
                HOFFS = 5'($urandom);
                VOFFS = 5'($urandom);
            end
            if (m_pos == 0) begin
                HOFFS = hoffs_tbl[m_frames % 4];
                VOFFS = voffs_tbl[m_frames % 4];
            end
        end
        check("frames_reached", 32'((m_frames >= tgt) ? tgt : m_frames), 32'(tgt));

        // Asynchronous reset in the middle of a line
        FLIP = 1'b1;
        cyc  = 0;
        while ((m_pos % HT) != 100 && cyc < 2000) begin
            @(negedge MCLK);
            cyc++;
            CE_PIX = 1'b1;
        end
        check("midline_reached", 32'(m_pos % HT), 32'd100);
        RESET_N = 1'b0;
        #1;
        check("rst_hblk",     32'(HBLK),     32'd1);
        check("rst_vblk",     32'(VBLK),     32'd1);
        check("rst_hsyn",     32'(HSYN),     32'd1);
        check("rst_vsyn",     32'(VSYN),     32'd1);
        check("rst_frame_st", 32'(FRAME_ST), 32'd0);
        check("rst_orgb",     32'(oRGB),     32'd0);
        check("rst_hpos",     32'(HPOS),     32'(HACT - 1));
        check("rst_vpos",     32'(VPOS),     32'(VACT - 1));
        repeat (2) @(negedge MCLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 3000 && n_fail <= 50; i++) begin
            @(negedge MCLK);
            CE_PIX = ($urandom_range(0, 3) != 0);
            iRGB   = 12'($urandom);
            FLIP   = (i < 1500);
        end
        CE_PIX = 1'b0;
        repeat (2) @(negedge MCLK);
        check("frame_st_count", 32'(dut_fst_cnt), 32'(m_fst_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores; the next generation of the per-game fixed H/V counter.
- Runs on the system clock with a pixel clock-enable rather than a derived pixel clock.
- Produces pixel coordinates for the game core, blank/sync to the video output chain, and blanked RGB.
- Adds generic totals/active sizes, signed sync offsets latched at frame start, cocktail flip, and a programmable pixel-pipeline delay.

Parameters:
- CW, 10, counter width (H_TOTAL and V_TOTAL must be ≤ 2^CW).
- RGB_W, 12, pixel data width.
- H_TOTAL, 384, pixel clocks per line.
- H_ACT, 256, active pixels per line.
- V_TOTAL, 262, lines per frame.
- V_ACT, 224, active lines per frame.
- H_SYNC_BASE, 304, nominal HSYNC start count.
- H_SYNC_W, 32, HSYNC width in pixels.
- V_SYNC_BASE, 236, nominal VSYNC start line.
- V_SYNC_W, 3, VSYNC width in lines.
- H_STEP, 2, pixels per HOFFS unit.
- V_STEP, 1, lines per VOFFS unit.
- OFS_W, 5, offset input width (signed two's complement).
- PIX_DLY, 2, CE cycles of core pixel latency (0..7).

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE_PIX  in  1  pixel clock-enable; all state advances only when high.
- HOFFS  in  OFS_W  signed HSYNC offset.
- VOFFS  in  OFS_W  signed VSYNC offset.
- FLIP  in  1  cocktail flip of reported coordinates.
- iRGB  in  RGB_W  pixel from core, valid PIX_DLY CE cycles after its HPOS/VPOS.
- HPOS  out  CW  horizontal coordinate.
- VPOS  out  CW  vertical coordinate.
- oRGB  out  RGB_W  blanked pixel.
- HBLK  out  1  horizontal blank, active high.
- VBLK  out  1  vertical blank, active high.
- HSYN  out  1  horizontal sync, active low.
- VSYN  out  1  vertical sync, active low.
- FRAME_ST  out  1  one-MCLK pulse on the CE at which hcnt=0 and vcnt=0.

Behaviour:
- Reset values: hcnt=0, vcnt=0; delay line filled with blanked/sync-inactive state; oRGB=0, HBLK=1, VBLK=1, HSYN=1, VSYN=1, FRAME_ST=0. Latched offsets are 0. Asserting reset mid-frame returns to this state immediately.
- Counters, on CE: hcnt increments and wraps H_TOTAL-1→0. On that wrap, vcnt increments and wraps V_TOTAL-1→0. No change without CE.
- Coordinates are combinational from the counters:
  - HPOS = FLIP && hcnt<H_ACT ? H_ACT-1-hcnt : hcnt.
  - VPOS = FLIP && vcnt<V_ACT ? V_ACT-1-vcnt : vcnt.
  - Outside the active region, coordinates are never mirrored.
- Raw timing, a function of the counters:
  - hb = hcnt≥H_ACT; vb = vcnt≥V_ACT.
  - hs_n low for hcnt in [HSB, HSB+H_SYNC_W).
  - vs_n low for vcnt in [VSB, VSB+V_SYNC_W).
- Sync start positions:
  - HSB = H_SYNC_BASE + sext(HOFFS_L)*H_STEP.
  - VSB = V_SYNC_BASE + sext(VOFFS_L)*V_STEP.
  - Computed in CW+OFS_W+2 signed bits, then clamped to [H_ACT, H_TOTAL-H_SYNC_W] and [V_ACT, V_TOTAL-V_SYNC_W]. Sync never overlaps active video and never wraps.
- HOFFS/VOFFS are latched into HOFFS_L/VOFFS_L only on the CE at which hcnt=0 and vcnt=0. Mid-frame changes have no effect until the next frame.
- Delay line: {hb, vb, hs_n, vs_n} pass through a PIX_DLY-stage shift register advanced on CE, then one output register on CE.
  - Blank/sync outputs lag the counters by PIX_DLY+1 CE.
  - oRGB is registered on the same CE: 0 if the delayed hb|vb is set, else iRGB.
  - PIX_DLY=0 means no shift stages, output register only.
- FRAME_ST is combinational CE & (hcnt==0) & (vcnt==0), registered to a one-MCLK pulse. Same latency as the other outputs.
- Simultaneous offset change and frame start: the new value is used for the starting frame.

Decomposition:
- Shared package video_pkg: sync/blank bundle struct {hb, vb, hs_n, vs_n}; localparams for the default 256x224 timing; the clamp function.
- One natural sub-module, vtg_delay_line (parametrised depth/width CE shift register), reusable by other cores.

Test Plan:
- Reset release with CE every 8 MCLK, defaults → HBLK falls 3 CE after hcnt=0. Line period 384 CE, frame 384*262 CE, FRAME_ST once per frame.
- HOFFS=0, VOFFS=0 → HSYN low for delayed hcnt 304..335, VSYN low for lines 236..238. HOFFS=+15 → 334..365. HOFFS=-16 → 272..303.
- VOFFS=-16 → VSB clamped to 224. VOFFS=+15 → 251, still ending at line 253 < 262.
- Change HOFFS mid-frame at vcnt=100 → sync position unchanged until the line after FRAME_ST.
- FLIP=1 → HPOS=255 at hcnt=0, 0 at hcnt=255, 300 at hcnt=300. VPOS=223 at vcnt=0.
- iRGB=12'hABC constant, PIX_DLY=2 → oRGB=0 during delayed blank, 12'hABC otherwise. Assert RESET_N low mid-line → all outputs at reset values within the same cycle.
